// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Streams a program image from a byte-wide valid/ready source into the
// instruction SRAM write port. While the load is in progress the processor
// is held in reset. Once the load completes the processor is released, and
// fetch then starts at LOAD_BASE.
//
// Stream format (all fields big-endian, first byte -> bits [31:24]):
//   length N (4 bytes), then N data words (4 bytes each)
//   [+ checksum word (4 bytes) when IMEM_LOADER_CHECKSUM_EN is defined]
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, a CHK state follows the last data word. It accepts a
//   checksum word and compares it with the modulo-2^32 sum of the length
//   word plus all data words. A match goes to DONE, a mismatch goes to ERR.
//   When undefined, the last write goes straight to DONE.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   reset       asynchronous, active-high; returns the block to IDLE
//   start       one-cycle pulse, begins a load (honoured in IDLE/DONE/ERR)
//   byte_valid  source presents a byte on byte_data
//   byte_data   stream byte
//   byte_ready  loader accepts a byte this cycle
//   mem_cs      instruction SRAM chip select (high only in the write cycle)
//   mem_we      instruction SRAM write enable, one pulse per word
//   mem_addr    write byte address
//   mem_din     write data
//   cpu_reset   holds the processor in reset
//   done        image loaded, processor released
//   error       load aborted
//   word_count  words written so far in the current load
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter logic [31:0] LOAD_BASE = 32'h0040_0020,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [31:0] word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    state_t      state;
    logic [1:0]  byte_cnt;    // byte position within the current 4-byte field
    logic [23:0] shift_reg;   // first three bytes of the field being assembled
    logic [31:0] len_words;   // latched image length N
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] csum_acc;    // running sum of length word plus data words
`endif

    logic        xfer;
    logic [31:0] assembled;
    logic        last_word;

    assign xfer      = byte_valid & byte_ready;
    // The complete field becomes available as the 4th byte is accepted.
    assign assembled = {shift_reg, byte_data};
    // word_count is updated at the end of the write cycle, so the word being
    // written is the last one when the count, plus one, reaches N.
    assign last_word = (word_count + 32'd1) == len_words;

    // All outputs are registered. Each output is set on the edge that enters
    // the state which owns that output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            byte_cnt   <= '0;
            shift_reg  <= '0;
            len_words  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_acc   <= '0;
`endif
            byte_ready <= 1'b0;
            mem_cs     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= LOAD_BASE;
            mem_din    <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout. Every right-hand side
            // sees the pre-edge value, so the order of statements below does
            // not change the result.
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_LEN;
                        byte_cnt   <= '0;
                        word_count <= '0;
                        mem_addr   <= LOAD_BASE;
                        byte_ready <= 1'b1;
                        cpu_reset  <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                    end
                end

                S_LEN: begin
                    if (xfer) begin
                        byte_cnt  <= byte_cnt + 2'd1;   // wraps to 0 after the 4th byte
                        shift_reg <= assembled[23:0];
                        if (byte_cnt == 2'd3) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum_acc <= assembled;
`endif
                            if (assembled == 32'd0) begin
                                state      <= S_DONE;
                                byte_ready <= 1'b0;
                                cpu_reset  <= 1'b0;
                                done       <= 1'b1;
                            end else if (assembled > 32'(MAX_WORDS)) begin
                                state      <= S_ERR;
                                byte_ready <= 1'b0;
                                error      <= 1'b1;
                            end else begin
                                len_words  <= assembled;
                                state      <= S_DATA;
                            end
                        end
                    end
                end

                S_DATA: begin
                    if (xfer) begin
                        byte_cnt  <= byte_cnt + 2'd1;
                        shift_reg <= assembled[23:0];
                        if (byte_cnt == 2'd3) begin
                            state      <= S_WRITE;
                            byte_ready <= 1'b0;
                            mem_cs     <= 1'b1;
                            mem_we     <= 1'b1;
                            mem_din    <= assembled;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum_acc   <= csum_acc + assembled;
`endif
                        end
                    end
                end

                // Single write cycle: the strobe drops on the next edge, which
                // also advances the address to the next word.
                S_WRITE: begin
                    mem_cs     <= 1'b0;
                    mem_we     <= 1'b0;
                    mem_addr   <= mem_addr + 32'd4;
                    word_count <= word_count + 32'd1;
                    if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state      <= S_CHK;
                        byte_ready <= 1'b1;
`else
                        state      <= S_DONE;
                        cpu_reset  <= 1'b0;
                        done       <= 1'b1;
`endif
                    end else begin
                        state      <= S_DATA;
                        byte_ready <= 1'b1;
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (xfer) begin
                        byte_cnt  <= byte_cnt + 2'd1;
                        shift_reg <= assembled[23:0];
                        if (byte_cnt == 2'd3) begin
                            byte_ready <= 1'b0;
                            if (assembled == csum_acc) begin
                                state     <= S_DONE;
                                cpu_reset <= 1'b0;
                                done      <= 1'b1;
                            end else begin
                                state     <= S_ERR;
                                error     <= 1'b1;
                            end
                        end
                    end
                end
`endif

                default: begin
                    state      <= S_IDLE;
                    byte_ready <= 1'b0;
                    mem_cs     <= 1'b0;
                    mem_we     <= 1'b0;
                    cpu_reset  <= 1'b1;
                    done       <= 1'b0;
                    error      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. It drives randomized byte streams with
// random valid gaps. A stream-position model predicts which cycle carries each
// write strobe and which address/data it must carry. End-of-load status is
// predicted from the image length (and from the checksum, when
// IMEM_LOADER_CHECKSUM_EN is defined).
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam logic [31:0] LOAD_BASE = 32'h0040_0020;
    localparam int          MAX_WORDS = 1024;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        mem_cs;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [31:0] word_count;

    imem_loader #(.LOAD_BASE(LOAD_BASE), .MAX_WORDS(MAX_WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_cs     (mem_cs),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int n_checks = 0;
    int n_err    = 0;

    // Model state shared with the monitor.
    wr_t         exp_wr[$];     // writes still expected in this load
    logic [31:0] log_addr[$];   // writes observed in this load
    logic [31:0] log_data[$];
    logic [31:0] words_q[$];    // image words for the next run_load
    int          pos = 0;       // accepted bytes in the current stream
    int          model_n = 0;   // number of data words that will be written
    int          load_writes = 0;
    bit          exp_we = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle monitor. Inputs change at posedge+1, so at negedge both the
    // inputs and the registered outputs are stable.
    always @(negedge clk) begin
        if (reset) begin
            exp_we = 1'b0;
        end else begin
            check("mem_we", 32'(mem_we), 32'(exp_we));
            check("mem_cs", 32'(mem_cs), 32'(exp_we));
            if (exp_we) check("ready_in_write", 32'(byte_ready), 32'd0);
            if (mem_we) begin
                if (exp_wr.size() == 0) begin
                    check("extra_write", 32'(exp_wr.size()), 32'd1);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("wr_addr", mem_addr, w.addr);
                    check("wr_data", mem_din, w.data);
                end
                log_addr.push_back(mem_addr);
                log_data.push_back(mem_din);
                load_writes++;
            end
            // A transfer at the coming edge that completes a data word must
            // produce the write strobe in the following cycle.
            exp_we = 1'b0;
            if (byte_valid && byte_ready) begin
                if (pos >= 4 && pos < 4 + 4 * model_n && (pos % 4) == 3) exp_we = 1'b1;
                pos++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bytes(input logic [7:0] q[$], input int max_gap, input bit poke);
        for (int i = 0; i < q.size(); i++) begin
            int gap;
            int t;
            if (poke && i == 6) begin
                // start mid-load must be ignored
                byte_valid = 1'b0;
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            gap = int'($urandom_range(max_gap, 0));
            byte_valid = 1'b0;
            repeat (gap) begin
                byte_data = 8'($urandom);
                tick();
            end
            byte_valid = 1'b1;
            byte_data  = q[i];
            t = 0;
            while (!byte_ready && t < 50) begin
                tick();
                t++;
            end
            if (!byte_ready) begin
                check("byte_timeout", 32'(t), 32'd0);
                byte_valid = 1'b0;
                return;
            end
            tick();
        end
        byte_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_mem_cs"},     32'(mem_cs),     32'd0);
        check({tag, "_mem_we"},     32'(mem_we),     32'd0);
        check({tag, "_mem_addr"},   mem_addr,        LOAD_BASE);
        check({tag, "_mem_din"},    mem_din,         32'd0);
        check({tag, "_cpu_reset"},  32'(cpu_reset),  32'd1);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_error"},      32'(error),      32'd0);
        check({tag, "_word_count"}, word_count,      32'd0);
    endtask

    // Full load of length n using words_q, with status checks at the end.
    task automatic run_load(input logic [31:0] n, input int max_gap, input bit poke, input bit bad_csum);
        logic [7:0] q[$];
        bit         len_ok;
        bit         exp_done;
        int         late;
        int         t;
        len_ok = (n >= 32'd1) && (n <= 32'(MAX_WORDS));
        exp_wr.delete();
        log_addr.delete();
        log_data.delete();
        model_n     = len_ok ? int'(n) : 0;
        pos         = 0;
        load_writes = 0;
        for (int b = 3; b >= 0; b--) q.push_back(n[8*b +: 8]);
        for (int i = 0; i < model_n; i++) begin
            wr_t w;
            logic [31:0] wd;
            wd = words_q[i];
            w.addr = LOAD_BASE + 32'(4 * i);
            w.data = wd;
            exp_wr.push_back(w);
            for (int b = 3; b >= 0; b--) q.push_back(wd[8*b +: 8]);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (len_ok) begin
            logic [31:0] sum;
            sum = n;
            for (int i = 0; i < model_n; i++) sum = sum + words_q[i];
            if (bad_csum) sum = sum + 32'd1;
            for (int b = 3; b >= 0; b--) q.push_back(sum[8*b +: 8]);
        end
`endif
        exp_done = (n == 32'd0) || (len_ok && !(CSUM_ON && bad_csum));

        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_cpu_reset", 32'(cpu_reset), 32'd1);
        check("start_done",      32'(done),      32'd0);
        check("start_error",     32'(error),     32'd0);
        check("start_ready",     32'(byte_ready), 32'd1);

        send_bytes(q, max_gap, poke);

        // Bytes offered after the image must stay unaccepted.
        byte_valid = 1'b1;
        late = 0;
        repeat (6) begin
            byte_data = 8'($urandom);
            if (byte_ready) late++;
            tick();
        end
        byte_valid = 1'b0;
        check("late_accept", 32'(late), 32'd0);

        t = 0;
        while (!(done || error) && t < 10) begin
            tick();
            t++;
        end
        check("end_done",      32'(done),        32'(exp_done));
        check("end_error",     32'(error),       32'(!exp_done));
        check("end_cpu_reset", 32'(cpu_reset),   32'(!exp_done));
        check("end_ready",     32'(byte_ready),  32'd0);
        check("end_word_count", word_count,      32'(model_n));
        check("end_writes",    32'(load_writes), 32'(model_n));
        check("pending_writes", 32'(exp_wr.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        @(negedge clk);
        check_reset_values("reset");
        tick();
        reset = 1'b0;
        tick();

        // Two-word directed image, with literal pins on the model
        words_q = {32'hDEADBEEF, 32'h01234567};
        run_load(32'd2, 0, 1'b0, 1'b0);
        check("t1_nwrites", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            check("t1_addr0", log_addr[0], 32'h0040_0020);
            check("t1_data0", log_data[0], 32'hDEADBEEF);
            check("t1_addr1", log_addr[1], 32'h0040_0024);
            check("t1_data1", log_data[1], 32'h01234567);
        end
        check("t1_word_count", word_count, 32'd2);

        // Zero-length image
        run_load(32'd0, 1, 1'b0, 1'b0);
        check("t2_nwrites", 32'(log_addr.size()), 32'd0);

        // Length just above the limit, then recovery
        run_load(32'h0000_0401, 1, 1'b0, 1'b0);
        check("t3_error", 32'(error), 32'd1);
        words_q = {32'hCAFEF00D};
        run_load(32'd1, 2, 1'b0, 1'b0);
        check("t3_recover_done", 32'(done), 32'd1);

        // Three-word image with random valid gaps
        words_q = {32'h11223344, 32'h55667788, 32'h99AABBCC};
        run_load(32'd3, 3, 1'b1, 1'b0);

        // Reset after 2 bytes of the third word of a 3-word load
        begin
            logic [7:0] q[$];
            logic [31:0] w3[3];
            w3 = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3};
            exp_wr.delete();
            log_addr.delete();
            log_data.delete();
            model_n = 3;
            pos = 0;
            load_writes = 0;
            q = {8'h00, 8'h00, 8'h00, 8'h03};
            for (int i = 0; i < 2; i++) begin
                wr_t w;
                w.addr = LOAD_BASE + 32'(4 * i);
                w.data = w3[i];
                exp_wr.push_back(w);
                for (int b = 3; b >= 0; b--) q.push_back(w3[i][8*b +: 8]);
            end
            q.push_back(w3[2][31:24]);
            q.push_back(w3[2][23:16]);
            start = 1'b1;
            tick();
            start = 1'b0;
            send_bytes(q, 2, 1'b0);
            reset = 1'b1;
            @(negedge clk);
            check_reset_values("midreset");
            tick();
            reset = 1'b0;
            repeat (3) tick();
            check("midreset_writes", 32'(load_writes), 32'd2);
            check("midreset_pending", 32'(exp_wr.size()), 32'd0);
        end

        // Restart after the abort loads cleanly from LOAD_BASE
        words_q = {32'h0BADC0DE, 32'h12345678, 32'h87654321};
        run_load(32'd3, 1, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        words_q = {32'h0000_0010};
        run_load(32'd1, 1, 1'b0, 1'b0);
        check("csum_good_done", 32'(done), 32'd1);
        run_load(32'd1, 1, 1'b0, 1'b1);
        check("csum_bad_error", 32'(error), 32'd1);
        check("csum_bad_cpu_reset", 32'(cpu_reset), 32'd1);
`endif

        // Randomized loads
        for (int k = 0; k < 10; k++) begin
            int          r;
            logic [31:0] n;
            r = int'($urandom_range(9, 0));
            if (r == 0)      n = 32'd0;
            else if (r == 1) n = 32'(MAX_WORDS + 1) + 32'($urandom_range(5000, 0));
            else if (r == 2) n = 32'hFFFF_FFFF;
            else             n = 32'($urandom_range(6, 1));
            words_q.delete();
            for (int i = 0; i < 6; i++) words_q.push_back($urandom);
            run_load(n, int'($urandom_range(3, 0)), ($urandom_range(1, 0) == 1) && n >= 32'd2 && n <= 32'd6,
                     $urandom_range(3, 0) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart to the fetch path: streams a program image into instruction SRAM through a byte-wide valid/ready interface.
- Holds the processor in reset while loading, then releases it so fetch begins at LOAD_BASE.
- Sits between a host/UART byte source and the instruction memory write port (cs/we/addr/din).

Parameters:
- LOAD_BASE, 32'h00400020, byte address of first word written; matches processor PC start.
- MAX_WORDS, 1024, largest accepted image length in words.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; returns block to IDLE
- start  input  1  one-cycle pulse: begin a load (honoured in IDLE, DONE, ERR only)
- byte_valid  input  1  source has a byte on byte_data
- byte_data  input  8  stream byte
- byte_ready  output  1  loader accepts byte this cycle (transfer = byte_valid & byte_ready)
- mem_cs  output  1  instruction SRAM chip select
- mem_we  output  1  instruction SRAM write enable, one-cycle pulse per word
- mem_addr  output  32  write byte address
- mem_din  output  32  write data
- cpu_reset  output  1  holds processor (PC register aload) in reset
- done  output  1  image loaded, processor released
- error  output  1  load aborted
- word_count  output  32  words written so far in current load

Behaviour:
- Reset values: byte_ready=0, mem_cs=0, mem_we=0, mem_addr=LOAD_BASE, mem_din=0, cpu_reset=1, done=0, error=0, word_count=0; state IDLE.
- Stream format: 4-byte length N, then N words of 4 bytes; all big-endian (first byte -> bits [31:24]).
- States:
  - IDLE: byte_ready=0, cpu_reset=1. start -> LEN; clears byte counter and word_count; mem_addr=LOAD_BASE.
  - LEN: byte_ready=1. After 4th byte: N=0 -> DONE; N>MAX_WORDS -> ERR; else latch N -> DATA.
  - DATA: byte_ready=1. Shift bytes into assembly register; on 4th byte -> WRITE.
  - WRITE (exactly 1 cycle): byte_ready=0, mem_cs=1, mem_we=1, mem_din=assembled word, mem_addr=current address. Next edge: mem_addr+=4, word_count+=1. Go to DONE if word_count reaches N (or CHK with CHECKSUM_EN), else DATA.
  - DONE: cpu_reset=0, done=1, byte_ready=0. start -> LEN (reload, cpu_reset reasserts same edge).
  - ERR: cpu_reset=1, error=1, byte_ready=0. start -> LEN with error cleared.
- Timing:
  - Latency: write strobe is the cycle after the 4th data byte is accepted.
  - Peak rate is 4 bytes per 5 cycles.
- Signal rules:
  - mem_cs/mem_we low outside WRITE.
  - mem_addr arithmetic is 32-bit modulo 2^32 (no wrap expected given MAX_WORDS).
- Edge cases:
  - start ignored in LEN/DATA/WRITE.
  - byte_valid without byte_ready is ignored with no side effects.
  - Bytes arriving after the final word stay unaccepted.
  - reset at any point, including mid-word or during WRITE: immediate return to reset values. Partial word is discarded, no further writes; memory contents already written are untouched.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN
- Defined: after the N-th word, state CHK accepts a 4-byte big-endian checksum, compared with the 32-bit modulo-2^32 sum of length word plus all data words.
  - Match -> DONE.
  - Mismatch -> ERR; cpu_reset stays 1.
- Undefined: no CHK state; last WRITE goes straight to DONE; stream carries no checksum.

Test Plan:
- Reset then start, stream 00 00 00 02, DE AD BE EF, 01 23 45 67 -> writes 0xDEADBEEF @0x00400020 and 0x01234567 @0x00400024, one mem_we pulse each; done=1, cpu_reset=0, word_count=2.
- Length 00 00 00 00 -> DONE after 4 bytes, zero mem_we pulses, cpu_reset=0.
- Length 0x00000401 (MAX_WORDS+1) -> error=1, cpu_reset=1, byte_ready=0; subsequent start plus valid 1-word image -> done=1, error=0.
- byte_valid toggled randomly (gaps of 0-3 cycles) through a 3-word image -> identical writes; no byte accepted during WRITE cycles.
- Assert reset after 2 bytes of word 2 in a 3-word load -> all outputs at reset values next cycle, no third write; restart loads cleanly from LOAD_BASE.
- With IMEM_LOADER_CHECKSUM_EN: image N=1, word 0x00000010, checksum 0x00000011 -> done=1; checksum 0x00000012 -> error=1, cpu_reset=1.
